// File: rtl/pipe_pkg.sv
// Shared pipeline package: fetch FSM encoding and boot PC.
// Also holds the PC increment helper used by the fetch controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    MD_WAIT = 2'd2,
    IM_WAIT = 2'd3
  } fstate_t;

  localparam logic [31:0] RESET_PC_DEF = 32'hFFFF_FFFC;

  function automatic logic [31:0] pc_inc(input logic [31:0] p);
    return p + 32'd4;
  endfunction

endpackage

// File: rtl/pipe_fetch_ctrl_if.sv
// Fetch-control bundle: IF/ID/EX status in, PC steering and stall out.
// The slave side is the controller; the master side is the pipeline.
interface pipe_fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      pc;
  logic [31:0]      br_target;
  logic [31:0]      j_target;
  logic [31:0]      jr_target;
  logic             id_branch_taken;
  logic             id_j;
  logic             id_jr;
  logic             ex_wreg;
  logic             ex_m2reg;
  logic [4:0]       ex_rd;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             md_start;
  logic             md_done;
  logic             imem_ready;
  logic [31:0]      npc;
  logic             wpcir;
  logic             id_bubble;
  logic             if_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output pc, br_target, j_target, jr_target,
    output id_branch_taken, id_j, id_jr,
    output ex_wreg, ex_m2reg, ex_rd,
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output md_start, md_done, imem_ready,
    input  npc, wpcir, id_bubble, if_flush,
    input  state, stall_cnt
  );

  modport slave (
    input  pc, br_target, j_target, jr_target,
    input  id_branch_taken, id_j, id_jr,
    input  ex_wreg, ex_m2reg, ex_rd,
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  md_start, md_done, imem_ready,
    output npc, wpcir, id_bubble, if_flush,
    output state, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_det.sv
// Load-use hazard compare between the EX load and the ID sources.
module pipe_hazard_det
  import pipe_pkg::*;
(
  input  logic       ex_wreg,
  input  logic       ex_m2reg,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_use_rs & (id_rs == ex_rd);
  assign rt_hit = id_use_rt & (id_rt == ex_rd);

  assign lu = ex_wreg & ex_m2reg & (ex_rd != 5'd0)
            & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_fetch_ctrl.sv
// Fetch controller: stall FSM, next-PC mux and saturating stall counter.
module pipe_fetch_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic              clock,
  input  logic              resetn,
  pipe_fetch_ctrl_if.slave  f
);

  fstate_t          state;
  fstate_t          nstate;
  logic             lu;
  logic [31:0]      redir;
  logic [31:0]      boot_npc;
  logic [31:0]      npc;
  logic             wpcir;
  logic             bubble;
  logic             flush;
  logic [CNT_W-1:0] cnt;

  pipe_hazard_det u_hz (
    .ex_wreg   (f.ex_wreg),
    .ex_m2reg  (f.ex_m2reg),
    .ex_rd     (f.ex_rd),
    .id_rs     (f.id_rs),
    .id_rt     (f.id_rt),
    .id_use_rs (f.id_use_rs),
    .id_use_rt (f.id_use_rt),
    .lu        (lu)
  );

  always_comb begin
    if (f.id_jr)                redir = f.jr_target;
    else if (f.id_j)            redir = f.j_target;
    else if (f.id_branch_taken) redir = f.br_target;
    else                        redir = pc_inc(f.pc);
  end

  // Boot PC check raises no flag; both arms yield pc+4.
  assign boot_npc = (f.pc == RESET_PC) ? RESET_PC + 32'd4
                                       : pc_inc(f.pc);

  always_comb begin
    nstate = state;
    npc    = redir;
    wpcir  = 1'b1;
    bubble = 1'b0;
    flush  = 1'b0;
    if (!resetn) begin
      npc   = boot_npc;
      flush = 1'b1;
    end else begin
      unique case (state)
        BOOT: begin
          npc    = boot_npc;
          flush  = 1'b1;
          nstate = RUN;
        end
        RUN: begin
          if (!f.imem_ready) begin
            wpcir  = 1'b0;
            bubble = 1'b1;
            nstate = IM_WAIT;
          end else if (lu) begin
            wpcir  = 1'b0;
            bubble = 1'b1;
          end else if (f.md_start) begin
            wpcir  = 1'b0;
            nstate = MD_WAIT;
          end
        end
        MD_WAIT: begin
          wpcir  = 1'b0;
          bubble = 1'b1;
          if (f.md_done) nstate = RUN;
        end
        IM_WAIT: begin
          if (f.imem_ready) begin
            nstate = RUN;
          end else begin
            wpcir  = 1'b0;
            bubble = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= BOOT;
      cnt   <= '0;
    end else begin
      state <= nstate;
      if (!wpcir && cnt != '1)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign f.npc       = npc;
  assign f.wpcir     = wpcir;
  assign f.id_bubble = bubble;
  assign f.if_flush  = flush;
  assign f.state     = state;
  assign f.stall_cnt = cnt;

endmodule
